dds_wave_gen: RTL and testbench

- DDS core that consumes the control-side interface: a 2-bit wave select and a 12-bit frequency tuning word.
- Runs a phase accumulator and maps the truncated phase to sine, square, triangle or sawtooth samples for an 8-bit parallel DAC.
- Wave-select changes take effect only at a phase wrap, so output periods are never torn.

---
 rtl/dds_wave_gen_if.sv | 17 +
 rtl/dds_wave_gen.sv | 97 +++++++++
 tb/tb_dds_wave_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dds_wave_gen_if.sv
// Control/DAC bundle for dds_wave_gen; there is no ready path, en=0 freezes the core.
// sync_pulse is present only when DDS_SYNC_PULSE_EN is defined.
interface dds_wave_gen_if #(parameter int DATA_W = 8);
  logic              en;
  logic [1:0]        switch;
  logic [11:0]       freq_word;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
`ifdef DDS_SYNC_PULSE_EN
  logic              sync_pulse;
  modport master (output en, switch, freq_word, input dac_data, dac_valid, sync_pulse);
  modport slave  (input en, switch, freq_word, output dac_data, dac_valid, sync_pulse);
`else
  modport master (output en, switch, freq_word, input dac_data, dac_valid);
  modport slave  (input en, switch, freq_word, output dac_data, dac_valid);
`endif
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: sine/square/triangle/saw; acc reaches dac_data 2 enabled edges later; en=0 holds all state.
// Optional DDS_SYNC_PULSE_EN adds sync_pulse, high on the first sample after each phase wrap.
module dds_wave_gen #(
  parameter int ACC_W  = 16,
  parameter int PH_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  dds_wave_gen_if.slave ctl
);

  // First quarter of the sine, sampled at half-step offsets so the quadrants mirror exactly.
  localparam logic [7:0] SINE_Q [0:63] = '{
    8'd129, 8'd132, 8'd135, 8'd138, 8'd142, 8'd145, 8'd148, 8'd151,
    8'd154, 8'd157, 8'd160, 8'd163, 8'd166, 8'd169, 8'd172, 8'd175,
    8'd178, 8'd181, 8'd183, 8'd186, 8'd189, 8'd192, 8'd194, 8'd197,
    8'd200, 8'd202, 8'd205, 8'd207, 8'd210, 8'd212, 8'd214, 8'd217,
    8'd219, 8'd221, 8'd223, 8'd225, 8'd227, 8'd229, 8'd231, 8'd233,
    8'd234, 8'd236, 8'd238, 8'd239, 8'd241, 8'd242, 8'd243, 8'd245,
    8'd246, 8'd247, 8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255
  };

  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic [1:0]        wave_sel;
  logic [1:0]        sel_b;
  logic [PH_W-1:0]   p;
  logic              vld_b;
  logic [DATA_W-1:0] dac_data_q;
  logic              dac_valid_q;
  logic [5:0]        k;
  logic [7:0]        rom_v;
  logic [7:0]        tri_v;
  logic [7:0]        wave;
`ifdef DDS_SYNC_PULSE_EN
  logic              wrap_a;
  logic              wrap_b;
  logic              sync_q;
`endif

  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(ctl.freq_word);

  // Quadrants 1 and 3 read the ROM backwards (~k == 63-k); the lower half is 255-x == ~x.
  always_comb begin
    k     = p[5:0];
    rom_v = p[6] ? SINE_Q[~k] : SINE_Q[k];
    tri_v = {p[6:0], 1'b0};
    wave  = '0;
    case (sel_b)
      2'b00:   wave = p[7] ? ~rom_v : rom_v;
      2'b01:   wave = p[7] ? 8'd0 : 8'hFF;
      2'b10:   wave = p[7] ? ~tri_v : tri_v;
      default: wave = p[7:0];
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc         <= '0;
      wave_sel    <= '0;
      p           <= '0;
      sel_b       <= '0;
      vld_b       <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
`ifdef DDS_SYNC_PULSE_EN
      wrap_a      <= 1'b0;
      wrap_b      <= 1'b0;
      sync_q      <= 1'b0;
`endif
    end else if (ctl.en) begin
      acc <= sum[ACC_W-1:0];
      // A zero tuning word never wraps, so the request is taken immediately.
      if (sum[ACC_W] || (ctl.freq_word == '0))
        wave_sel <= ctl.switch;
      p           <= acc[ACC_W-1 -: PH_W];
      sel_b       <= wave_sel;
      vld_b       <= 1'b1;
      dac_data_q  <= DATA_W'(wave);
      dac_valid_q <= vld_b;
`ifdef DDS_SYNC_PULSE_EN
      wrap_a      <= sum[ACC_W];
      wrap_b      <= wrap_a;
      sync_q      <= wrap_b;
`endif
    end
  end

  assign ctl.dac_data  = dac_data_q;
  assign ctl.dac_valid = dac_valid_q;
`ifdef DDS_SYNC_PULSE_EN
  assign ctl.sync_pulse = sync_q & ctl.en;
`endif

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: sample-history model checked every cycle plus directed literal expectations.
module tb_dds_wave_gen;
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  dds_wave_gen_if #(.DATA_W(8)) ctl();

  dds_wave_gen #(.ACC_W(16), .PH_W(8), .DATA_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ctl       (ctl)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int ed     = 0;
  int sine_tab [256];
  // State after each enabled edge since reset: index 0 is the reset state.
  int ph_q  [$];
  int sel_q [$];
  int wr_q  [$];

  function automatic int wave(int sel, int p);
    case (sel)
      0:       return sine_tab[p];
      1:       return (p < 128) ? 255 : 0;
      2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return p;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    ph_q.delete(); sel_q.delete(); wr_q.delete();
    ph_q.push_back(0); sel_q.push_back(0); wr_q.push_back(0);
  endtask

  // Model: phase arithmetic on plain integers; a sample appears two enabled edges later.
  initial begin
    for (int i = 0; i < 256; i++)
      sine_tab[i] = $rtoi($floor(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * (i + 0.5) / 256.0) + 0.5));
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else if (ctl.en) begin
        int last, s, w, sel;
        last = ph_q.size() - 1;
        s    = ph_q[last] + int'(ctl.freq_word);
        w    = (s >= 65536) ? 1 : 0;
        s    = s % 65536;
        sel  = (w == 1 || ctl.freq_word == 0) ? int'(ctl.switch) : sel_q[last];
        ph_q.push_back(s); sel_q.push_back(sel); wr_q.push_back(w);
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      begin
        int n;
        n = ph_q.size() - 1;
        if (n >= 2) begin
          check("dac_data", int'(ctl.dac_data), wave(sel_q[n-2], ph_q[n-2] / 256));
          check("dac_valid", int'(ctl.dac_valid), 1);
        end else begin
          check("dac_valid_fill", int'(ctl.dac_valid), 0);
          if (n == 0) check("dac_data_reset", int'(ctl.dac_data), 0);
        end
`ifdef DDS_SYNC_PULSE_EN
        check("sync_pulse", int'(ctl.sync_pulse),
              (n >= 2 && ctl.en == 1'b1) ? wr_q[n-2] : 0);
`endif
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic adv(int target);
    step(target - ed);
    ed = target;
  endtask

  // Reset, then one enabled edge with freq_word=0 so the requested wave is loaded.
  task automatic start(int sw, int fw);
    sys_rst_n     = 1'b0;
    ctl.en        = 1'b1;
    ctl.switch    = 2'(sw);
    ctl.freq_word = 12'd0;
    step(1);
    sys_rst_n = 1'b1;
    step(1);
    ctl.freq_word = 12'(fw);
    ed = 1;
  endtask

  initial begin
    ctl.en        = 1'b0;
    ctl.switch    = 2'd0;
    ctl.freq_word = 12'd0;
    #1;
    check("reset_dac_data", int'(ctl.dac_data), 0);
    check("reset_dac_valid", int'(ctl.dac_valid), 0);
    step(1);

    // Sawtooth, slow tuning word: one code step every 32 samples.
    start(3, 8);
    check("t1_valid_e1", int'(ctl.dac_valid), 0);
    adv(2);   check("t1_valid_e2", int'(ctl.dac_valid), 1);
              check("t1_e2_reset_sine", int'(ctl.dac_data), 129);
    adv(3);   check("t1_e3", int'(ctl.dac_data), 0);
    adv(34);  check("t1_e34", int'(ctl.dac_data), 0);
    adv(35);  check("t1_e35", int'(ctl.dac_data), 1);

    // Sawtooth one code per cycle, including the wrap.
    start(3, 256);
    adv(4);   check("t2_e4", int'(ctl.dac_data), 1);
    adv(258); check("t2_top", int'(ctl.dac_data), 255);
    adv(259); check("t2_wrap", int'(ctl.dac_data), 0);

    // Square: 16 high, 16 low.
    start(1, 2048);
    adv(3);   check("t3_first", int'(ctl.dac_data), 255);
    adv(18);  check("t3_last_high", int'(ctl.dac_data), 255);
    adv(19);  check("t3_first_low", int'(ctl.dac_data), 0);
    adv(35);  check("t3_next_period", int'(ctl.dac_data), 255);

    // Sine quadrant points.
    start(0, 256);
    adv(3);   check("t4_p0", int'(ctl.dac_data), 129);
    adv(67);  check("t4_p64", int'(ctl.dac_data), 255);
    adv(131); check("t4_p128", int'(ctl.dac_data), 126);
    adv(195); check("t4_p192", int'(ctl.dac_data), 0);
    adv(259); check("t4_repeat", int'(ctl.dac_data), 129);

    // Wave change requested mid-period only lands after the wrap.
    start(3, 256);
    adv(101); ctl.switch = 2'd1;
    adv(200); check("t5_saw_continues", int'(ctl.dac_data), 197);
    adv(258); check("t5_saw_end", int'(ctl.dac_data), 255);
`ifdef DDS_SYNC_PULSE_EN
              check("t5_sync_before", int'(ctl.sync_pulse), 0);
`endif
    adv(259); check("t5_square_first", int'(ctl.dac_data), 255);
`ifdef DDS_SYNC_PULSE_EN
              check("t5_sync_on_wrap", int'(ctl.sync_pulse), 1);
`endif
    adv(260); check("t5_square_second", int'(ctl.dac_data), 255);
`ifdef DDS_SYNC_PULSE_EN
              check("t5_sync_after", int'(ctl.sync_pulse), 0);
`endif

    // Zero tuning word: switch applied at once, output constant.
    ctl.freq_word = 12'd0;
    ctl.switch    = 2'd2;
    adv(263); check("t6_triangle", int'(ctl.dac_data), 6);
    adv(264); check("t6_constant", int'(ctl.dac_data), 6);

    // Enable low freezes everything.
    ctl.en = 1'b0;
    step(5);
    check("t7_frozen_data", int'(ctl.dac_data), 6);
    check("t7_frozen_valid", int'(ctl.dac_valid), 1);
    ctl.en        = 1'b1;
    ctl.freq_word = 12'd300;
    ctl.switch    = 2'd0;
    adv(600);
    ctl.freq_word = 12'd4095;
    ctl.switch    = 2'd2;
    adv(700);

    // Asynchronous reset mid-cycle.
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t8_async_data", int'(ctl.dac_data), 0);
    check("t8_async_valid", int'(ctl.dac_valid), 0);
    step(2);
    sys_rst_n = 1'b1;
    step(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
